duck_motion: RTL and testbench

Per-duck motion and hit controller feeding the color mapper. Holds the duck's screen position, direction, animation frame and life-cycle state, updated once per video frame. It produces the `is_duck` / `duck_addr` pair the color mapper uses for every pixel, and reports hit and escape events to the game-state logic.

---
 rtl/duck_pkg.sv | 25 ++
 rtl/frame_tick.sv | 28 ++
 rtl/duck_motion.sv | 186 ++++++++++++++++++
 tb/tb_duck_motion.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// duck_pkg: shared states, screen/sprite constants and box helper for the duck controller
package duck_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLY    = 3'd1,
        HIT    = 3'd2,
        FALL   = 3'd3,
        ESCAPE = 3'd4,
        DONE   = 3'd5
    } duck_state_t;

    localparam int SPRITE_W = 64;
    localparam int SCREEN_W = 640;
    localparam int X_MAX    = SCREEN_W - SPRITE_W;

    localparam logic [1:0] FRAME_HIT  = 2'd2;
    localparam logic [1:0] FRAME_FALL = 2'd3;

    // True when v lies in [base, base + SPRITE_W - 1]; the upper bound is widened so it never wraps
    function automatic logic in_span(input logic [9:0] base, input logic [9:0] v);
        return (v >= base) && ({1'b0, v} <= ({1'b0, base} + 11'(SPRITE_W - 1)));
    endfunction

endpackage

// File: rtl/frame_tick.sv
// frame_tick: synchronizes the vsync-rate frame clock and emits a one-cycle tick per rising edge
module frame_tick (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_frame_clk,
    output logic o_tick
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       r_tick;

    // Two-flop synchronizer followed by a registered rising-edge detector
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_frame_clk};
            r_prev <= r_sync[1];
            r_tick <= r_sync[1] & ~r_prev;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/duck_motion.sv
// duck_motion: per-duck position, life-cycle FSM, hit/escape events and sprite pixel lookup
module duck_motion
    import duck_pkg::*;
#(
    parameter int SPEED      = 2,
    parameter int FALL_SPEED = 4,
    parameter int FLY_FRAMES = 600,
    parameter int HIT_FRAMES = 30,
    parameter int GRASS_Y    = 400
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic [9:0]  start_x,
    input  logic        shot,
    input  logic [9:0]  cursor_x,
    input  logic [9:0]  cursor_y,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        is_duck,
    output logic [15:0] duck_addr,
    output logic        duck_hit,
    output logic        duck_escaped,
    output logic [2:0]  duck_state
);

    localparam int FLOOR_Y = GRASS_Y - SPRITE_W;
    localparam int FW      = $clog2(FLY_FRAMES + 1);
    localparam int HW      = $clog2(HIT_FRAMES + 1);

    localparam logic [10:0] L_SPEED = 11'(SPEED);
    localparam logic [10:0] L_FALL  = 11'(FALL_SPEED);
    localparam logic [10:0] L_FLOOR = 11'(FLOOR_Y);
    localparam logic [10:0] L_XMAX  = 11'(X_MAX);
    localparam logic [9:0]  S_SPEED = 10'(SPEED);
    localparam logic [9:0]  S_FLOOR = 10'(FLOOR_Y);
    localparam logic [9:0]  S_XMAX  = 10'(X_MAX);

    logic          w_tick;
    duck_state_t   r_state, w_state;
    logic [9:0]    r_x, r_y, w_x, w_y;
    logic          r_dxn, r_dyn, w_dxn, w_dyn;
    logic [FW-1:0] r_fly, w_fly;
    logic [HW-1:0] r_hc, w_hc;
    logic [2:0]    r_acnt, w_acnt;
    logic          r_anim, w_anim;
    logic          r_hit, w_hit, r_esc, w_esc;
    logic [10:0]   w_xs, w_ys, w_fall;
    logic          w_x_lo, w_x_hi, w_y_lo, w_y_hi;
    logic          w_shot_hit, w_active;
    logic [1:0]    w_frame;
    logic [5:0]    w_dx, w_dy;

    frame_tick u_tick (
        .i_clk       (Clk),
        .i_rst       (Reset),
        .i_frame_clk (frame_clk),
        .o_tick      (w_tick)
    );

    // Candidate flight step in 11 bits so edge checks happen before any wrap
    assign w_xs   = r_dxn ? {1'b0, r_x} - L_SPEED : {1'b0, r_x} + L_SPEED;
    assign w_ys   = r_dyn ? {1'b0, r_y} - L_SPEED : {1'b0, r_y} + L_SPEED;
    assign w_x_lo = r_dxn && ({1'b0, r_x} < L_SPEED);
    assign w_x_hi = !r_dxn && (w_xs > L_XMAX);
    assign w_y_lo = r_dyn && ({1'b0, r_y} < L_SPEED);
    assign w_y_hi = !r_dyn && (w_ys > L_FLOOR);
    assign w_fall = {1'b0, r_y} + L_FALL;

    assign w_shot_hit = shot && in_span(r_x, cursor_x) && in_span(r_y, cursor_y);

    // Next-state and next-datapath logic; a hit in FLY takes priority over a same-cycle tick
    always_comb begin
        w_state = r_state;
        w_x     = r_x;
        w_y     = r_y;
        w_dxn   = r_dxn;
        w_dyn   = r_dyn;
        w_fly   = r_fly;
        w_hc    = r_hc;
        w_acnt  = r_acnt;
        w_anim  = r_anim;
        w_hit   = 1'b0;
        w_esc   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state = FLY;
                    w_x     = (start_x > S_XMAX) ? S_XMAX : start_x;
                    w_y     = S_FLOOR;
                    w_dxn   = 1'b0;
                    w_dyn   = 1'b1;
                    w_fly   = '0;
                end
            end
            FLY: begin
                if (w_shot_hit) begin
                    w_state = HIT;
                    w_hit   = 1'b1;
                    w_hc    = '0;
                end else if (w_tick) begin
                    w_x    = w_x_lo ? '0 : w_x_hi ? S_XMAX : w_xs[9:0];
                    w_dxn  = (w_x_lo || w_x_hi) ? ~r_dxn : r_dxn;
                    w_y    = w_y_lo ? '0 : w_y_hi ? S_FLOOR : w_ys[9:0];
                    w_dyn  = (w_y_lo || w_y_hi) ? ~r_dyn : r_dyn;
                    w_acnt = r_acnt + 3'd1;
                    w_anim = (r_acnt == 3'd7) ? ~r_anim : r_anim;
                    w_fly  = r_fly + FW'(1);
                    if (r_fly == FW'(FLY_FRAMES - 1))
                        w_state = ESCAPE;
                end
            end
            HIT: begin
                if (w_tick) begin
                    if (r_hc == HW'(HIT_FRAMES - 1))
                        w_state = FALL;
                    else
                        w_hc = r_hc + HW'(1);
                end
            end
            FALL: begin
                if (w_tick) begin
                    w_y = (w_fall >= L_FLOOR) ? S_FLOOR : w_fall[9:0];
                    if (w_fall >= L_FLOOR)
                        w_state = DONE;
                end
            end
            ESCAPE: begin
                if (w_tick) begin
                    w_acnt = r_acnt + 3'd1;
                    w_anim = (r_acnt == 3'd7) ? ~r_anim : r_anim;
                    if ({1'b0, r_y} < L_SPEED) begin
                        w_y     = '0;
                        w_state = DONE;
                        w_esc   = 1'b1;
                    end else begin
                        w_y = r_y - S_SPEED;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any pending event pulse
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= S_FLOOR;
            r_dxn   <= 1'b0;
            r_dyn   <= 1'b1;
            r_fly   <= '0;
            r_hc    <= '0;
            r_acnt  <= '0;
            r_anim  <= 1'b0;
            r_hit   <= 1'b0;
            r_esc   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_x     <= w_x;
            r_y     <= w_y;
            r_dxn   <= w_dxn;
            r_dyn   <= w_dyn;
            r_fly   <= w_fly;
            r_hc    <= w_hc;
            r_acnt  <= w_acnt;
            r_anim  <= w_anim;
            r_hit   <= w_hit;
            r_esc   <= w_esc;
        end
    end

    assign w_active = (r_state == FLY) || (r_state == HIT) || (r_state == FALL) || (r_state == ESCAPE);
    assign w_frame  = (r_state == HIT) ? FRAME_HIT : (r_state == FALL) ? FRAME_FALL : {1'b0, r_anim};
    assign w_dx     = DrawX[5:0] - r_x[5:0];
    assign w_dy     = DrawY[5:0] - r_y[5:0];

    assign is_duck      = w_active && in_span(r_x, DrawX) && in_span(r_y, DrawY);
    assign duck_addr    = is_duck ? {4'b0000, w_frame, w_dy, w_dx} : 16'h0000;
    assign duck_hit     = r_hit;
    assign duck_escaped = r_esc;
    assign duck_state   = r_state;

endmodule

// File: tb/tb_duck_motion.sv
// tb_duck_motion: directed checks of launch, bounce, hit, fall, escape, addressing and reset
module tb_duck_motion;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  start_x = '0;
    logic        shot = 1'b0;
    logic [9:0]  cursor_x = '0;
    logic [9:0]  cursor_y = '0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        is_duck;
    logic [15:0] duck_addr;
    logic        duck_hit;
    logic        duck_escaped;
    logic [2:0]  duck_state;

    int n_checks = 0;
    int n_errors = 0;
    int esc_seen = 0;
    int hit_seen = 0;

    duck_motion #(.FLY_FRAMES(10)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .start        (start),
        .start_x      (start_x),
        .shot         (shot),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .is_duck      (is_duck),
        .duck_addr    (duck_addr),
        .duck_hit     (duck_hit),
        .duck_escaped (duck_escaped),
        .duck_state   (duck_state)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample_pulses();
        @(negedge Clk);
        esc_seen += int'(duck_escaped);
        hit_seen += int'(duck_hit);
    endtask

    task automatic do_tick();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (6) sample_pulses();
        frame_clk = 1'b0;
        repeat (4) sample_pulses();
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
        #1;
    endtask

    task automatic launch(input logic [9:0] sx);
        @(negedge Clk);
        start   = 1'b1;
        start_x = sx;
        @(negedge Clk);
        start   = 1'b0;
    endtask

    task automatic fire(input logic [9:0] cx, input logic [9:0] cy);
        @(negedge Clk);
        cursor_x = cx;
        cursor_y = cy;
        shot     = 1'b1;
        @(negedge Clk);
        shot     = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge Clk);
        probe(10'd0, 10'd336);
        check("rst_state", 16'(duck_state), 16'd0);
        check("rst_is_duck", 16'(is_duck), 16'd0);
        check("rst_addr", duck_addr, 16'h0000);
        check("rst_hit", 16'(duck_hit), 16'd0);
        check("rst_esc", 16'(duck_escaped), 16'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Launch at x=100, box (100..163, 336..399)
        launch(10'd100);
        check("launch_state", 16'(duck_state), 16'd1);
        probe(10'd100, 10'd336); check("box_tl", 16'(is_duck), 16'd1);
        probe(10'd163, 10'd399); check("box_br", 16'(is_duck), 16'd1);
        probe(10'd164, 10'd336); check("box_right_out", 16'(is_duck), 16'd0);
        probe(10'd100, 10'd335); check("box_top_out", 16'(is_duck), 16'd0);
        probe(10'd105, 10'd339); check("fly_addr", duck_addr, 16'h00C5);

        // One tick: (102, 334)
        do_tick();
        probe(10'd102, 10'd334); check("step_in", 16'(is_duck), 16'd1);
        probe(10'd101, 10'd334); check("step_old_col", 16'(is_duck), 16'd0);

        // Shot one pixel right of the box misses
        fire(10'd166, 10'd344);
        check("miss_hit", 16'(duck_hit), 16'd0);
        check("miss_state", 16'(duck_state), 16'd1);

        // Hit inside the box
        fire(10'd112, 10'd344);
        check("hit_pulse", 16'(duck_hit), 16'd1);
        check("hit_state", 16'(duck_state), 16'd2);
        @(negedge Clk);
        check("hit_pulse_end", 16'(duck_hit), 16'd0);
        probe(10'd107, 10'd337); check("hit_addr", duck_addr, 16'h20C5);

        repeat (29) do_tick();
        check("hit_hold_29", 16'(duck_state), 16'd2);
        do_tick();
        check("fall_after_30", 16'(duck_state), 16'd3);
        probe(10'd107, 10'd337); check("fall_addr", duck_addr, 16'h30C5);
        do_tick();
        check("fall_done", 16'(duck_state), 16'd5);
        probe(10'd107, 10'd337); check("done_hidden", 16'(is_duck), 16'd0);

        // Right-wall bounce from x=575
        launch(10'd575);
        check("bounce_launch", 16'(duck_state), 16'd1);
        do_tick();
        probe(10'd576, 10'd334); check("bounce_576", 16'(is_duck), 16'd1);
        probe(10'd575, 10'd334); check("bounce_575_out", 16'(is_duck), 16'd0);
        do_tick();
        probe(10'd574, 10'd332); check("bounce_574", 16'(is_duck), 16'd1);
        probe(10'd573, 10'd332); check("bounce_573_out", 16'(is_duck), 16'd0);
        probe(10'd637, 10'd332); check("bounce_right_edge", 16'(is_duck), 16'd1);
        probe(10'd638, 10'd332); check("bounce_right_out", 16'(is_duck), 16'd0);

        // Shot coincident with tick: tick is sampled on the 4th edge after frame_clk rises
        @(negedge Clk);
        frame_clk = 1'b1;
        cursor_x  = 10'd584;
        cursor_y  = 10'd342;
        repeat (3) @(negedge Clk);
        shot = 1'b1;
        @(negedge Clk);
        shot = 1'b0;
        check("prio_hit", 16'(duck_hit), 16'd1);
        check("prio_state", 16'(duck_state), 16'd2);
        probe(10'd574, 10'd332); check("prio_pos_in", 16'(is_duck), 16'd1);
        probe(10'd573, 10'd332); check("prio_pos_unmoved", 16'(is_duck), 16'd0);
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);

        repeat (30) do_tick();
        check("prio_fall", 16'(duck_state), 16'd3);
        probe(10'd574, 10'd332); check("prefall_reset_vis", 16'(is_duck), 16'd1);

        // Reset mid-FALL clears everything immediately
        Reset = 1'b1;
        #1;
        check("midrst_state", 16'(duck_state), 16'd0);
        check("midrst_is_duck", 16'(is_duck), 16'd0);
        check("midrst_addr", duck_addr, 16'h0000);
        check("midrst_hit", 16'(duck_hit), 16'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Escape: start_x clamped to 576, 10 flight ticks then climb out
        launch(10'd600);
        probe(10'd576, 10'd336); check("clamp_in", 16'(is_duck), 16'd1);
        probe(10'd575, 10'd336); check("clamp_out", 16'(is_duck), 16'd0);
        repeat (9) do_tick();
        check("fly_9_ticks", 16'(duck_state), 16'd1);
        do_tick();
        check("escape_state", 16'(duck_state), 16'd4);
        probe(10'd563, 10'd319); check("escape_addr", duck_addr, 16'h10C5);
        esc_seen = 0;
        repeat (158) do_tick();
        check("escape_no_pulse", 16'(esc_seen), 16'd0);
        check("escape_still", 16'(duck_state), 16'd4);
        probe(10'd563, 10'd3); check("escape_top_addr", duck_addr, 16'h10C5);
        do_tick();
        check("escape_pulse_once", 16'(esc_seen), 16'd1);
        check("escape_done", 16'(duck_state), 16'd5);
        probe(10'd563, 10'd3); check("escape_hidden", 16'(is_duck), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
